right_shift_iter: RTL and testbench
===================================

# right_shift_iter

Iterative, handshaked right shifter; the right-direction companion of the generic combinational left shifter. One request is accepted at a time. The data is shifted over clog2(width) cycles, one shift-amount bit per cycle, and the result is held until it is consumed. Supports logical (zero fill) and arithmetic (sign fill) modes per request. Sits in datapaths where a full barrel shifter is too large and a fixed, known latency is acceptable.

## Interface
- `width`, default 8: bit width of data input and output. Must be >= 2; need not be a power of two.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `iBits`  in  width: bits to shift.
- `shift`  in  clog2(width): requested right-shift amount.
- `arith`  in  1: 1 = arithmetic (fill with `iBits[width-1]`); 0 = logical (fill with 0).
- `iValid`  in  1: request valid.
- `iReady`  out  1: block can accept a request.
- `oBits`  out  width: shifted result.
- `oValid`  out  1: result valid.
- `oReady`  in  1: consumer accepts the result.

## Operation
- **States:** Idle, Shift, Done. Let S = clog2(width).
- **Idle:**
  - `iReady` = 1.
  - On `iValid` && `iReady`: capture `iBits` into the data register, `shift` into the amount register, and `arith` plus the fill bit (`arith` & `iBits[width-1]`) into their registers.
  - Clear the stage counter and go to Shift.
- **Shift:**
  - Each cycle, for stage k = counter: if amount[k] = 1, then data <= data >> 2^k, with the vacated top 2^k bits set to the fill bit. Otherwise data is unchanged.
  - If 2^k >= width, an active stage fills the whole word.
  - After stage S-1, go to Done.
- **Done:**
  - `oValid` = 1 and `oBits` = data register.
  - On `oReady`, go to Idle.
  - `oBits` stays stable while `oValid` = 1 and `oReady` = 0.
- **Saturation:** shift amounts >= width (possible when width is not a power of two) give all-fill: 0 in logical mode, all copies of the sign bit in arithmetic mode.
- **Input sampling:** inputs are sampled only at the handshake. Later changes to `iBits`/`shift`/`arith` have no effect on the request in flight.
- **Idle with no request:** `iValid` outside Idle is ignored, and no request is queued. `oReady` outside Done is ignored.
- **Shift by 0:** not a special case. Latency is the same and the result equals `iBits`.

## Timing
- **Reset:** `rst` high at a rising edge gives, from the next cycle: state = Idle, `iReady` = 1, `oValid` = 0, `oBits` = 0, counter = 0.
- **Reset mid-operation:** reset in Shift or Done aborts and discards the request; no `oValid` pulse follows.
- **Latency:** accept edge at cycle T, then `oValid` = 1 from cycle T+S+1. For width=8, that is 4 cycles after accept.
- **Throughput:** at most one request per S+2 cycles, with `oReady` held high.
- **Derived outputs:** `iReady` and `oValid` are decoded from the state register only, with no combinational path from `iValid`/`oReady`.
- **Back-to-back:** the Done→Idle edge with `oReady` does not accept a new request in the same cycle. The next accept is at the earliest one cycle later.

## Structure
- **Shared package `RightShiftIter_defs`:** state enum typedef (Idle, Shift, Done).
- **Stage counter:** width clog2(S) + 1 bits; the width is computed inline from `width`.
- **Sub-module `RightShiftStage`** (combinational):
  - Inputs: data, stage index, enable, fill bit.
  - Output: conditionally shifted data.
  - Instantiated once and reused every Shift cycle.
- The FSM, the registers and the handshake stay in the top module.

## Test plan
- **Logical shift:** width=8, `iBits`=0xB4, `shift`=3, `arith`=0 → `oBits`=0x16, `oValid` rises exactly 4 cycles after accept.
- **Arithmetic shift:** width=8, `iBits`=0xB4, `shift`=3, `arith`=1 → 0xF6. `iBits`=0x74 under the same settings → 0x0E.
- **Shift by 0 and by 7:** width=8, `shift`=0 on 0xB4 → 0xB4 with latency still 4. `shift`=7 arithmetic on 0x80 → 0xFF; logical → 0x01.
- **Non-power-of-two width:** width=6, `iBits`=0x20, `shift`=7 → arithmetic 0x3F, logical 0x00.
- **Backpressure:** hold `oReady`=0 for 5 cycles in Done → `oBits` stable, `iReady`=0, and `iValid` pulses during that time produce no second result. Raising `oReady` → `iReady` = 1 on the next cycle.
- **Reset mid-operation:** assert `rst` during the second Shift cycle → next cycle Idle, `oValid`=0, `oBits`=0. A fresh request after reset completes correctly.

Source files
------------

// File: rtl/right_shift_iter_pkg.sv
// Shared definitions for the iterative right shifter.
// Holds the controller state encoding.
package RightShiftIter_defs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/right_shift_iter_stage.sv
// One conditional right-shift stage by 2^stage_i bits.
// Vacated top bits take the fill value.
module RightShiftStage #(
   parameter int width = 8,
   parameter int CW    = 2
) (
   input  logic [width-1:0] data_i,
   input  logic [CW-1:0]    stage_i,
   input  logic             en_i,
   input  logic             fill_i,
   output logic [width-1:0] data_o
);

   logic [31:0]      amt;
   logic [width-1:0] mask;

   // mask marks the vacated top bits; amt >= width makes it all ones
   always_comb begin
      amt    = 32'd1 << stage_i;
      mask   = ~({width{1'b1}} >> amt);
      data_o = data_i;
      if (en_i) begin
         data_o = (data_i >> amt) | (mask & {width{fill_i}});
      end
   end

endmodule

// File: rtl/right_shift_iter.sv
// Iterative handshaked right shifter, logical or arithmetic.
// One shift-amount bit is applied per cycle.
module right_shift_iter #(
   parameter int width = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [width-1:0]         iBits,
   input  logic [$clog2(width)-1:0] shift,
   input  logic                     arith,
   input  logic                     iValid,
   output logic                     iReady,
   output logic [width-1:0]         oBits,
   output logic                     oValid,
   input  logic                     oReady
);

   import RightShiftIter_defs::*;

   localparam int S  = $clog2(width);
   localparam int CW = $clog2(S) + 1;

   state_e           state_q, state_d;
   logic [width-1:0] data_q, data_d;
   logic [S-1:0]     amt_q, amt_d;
   logic             arith_q, arith_d;
   logic             fill_q, fill_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             stage_en;
   logic [width-1:0] stage_data;

   RightShiftStage #(
      .width (width),
      .CW    (CW)
   ) u_stage (
      .data_i  (data_q),
      .stage_i (cnt_q),
      .en_i    (stage_en),
      .fill_i  (arith_q & fill_q),
      .data_o  (stage_data)
   );

   always_comb begin
      stage_en = 1'b0;
      for (int k = 0; k < S; k++) begin
         if (cnt_q == CW'(k)) begin
            stage_en = amt_q[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      amt_d   = amt_q;
      arith_d = arith_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (iValid) begin
               data_d  = iBits;
               amt_d   = shift;
               arith_d = arith;
               fill_d  = arith & iBits[width-1];
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            data_d = stage_data;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(S - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (oReady) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         amt_q   <= '0;
         arith_q <= 1'b0;
         fill_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         amt_q   <= amt_d;
         arith_q <= arith_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
      end
   end

   assign iReady = (state_q == IDLE);
   assign oValid = (state_q == DONE);
   assign oBits  = data_q;

endmodule

// File: tb/tb_right_shift_iter.sv
// Bench for right_shift_iter at width 8 and width 6.
// Results are compared with an arithmetic reference model.
module tb_right_shift_iter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0] iBits8, oBits8;
   logic [2:0] shift8;
   logic       arith8, iValid8, iReady8, oValid8, oReady8;
   logic [5:0] iBits6, oBits6;
   logic [2:0] shift6;
   logic       arith6, iValid6, iReady6, oValid6, oReady6;

   int errors = 0;
   int checks = 0;

   right_shift_iter #(.width(8)) dut8 (
      .clk    (clk),
      .rst    (rst),
      .iBits  (iBits8),
      .shift  (shift8),
      .arith  (arith8),
      .iValid (iValid8),
      .iReady (iReady8),
      .oBits  (oBits8),
      .oValid (oValid8),
      .oReady (oReady8)
   );

   right_shift_iter #(.width(6)) dut6 (
      .clk    (clk),
      .rst    (rst),
      .iBits  (iBits6),
      .shift  (shift6),
      .arith  (arith6),
      .iValid (iValid6),
      .iReady (iReady6),
      .oBits  (oBits6),
      .oValid (oValid6),
      .oReady (oReady6)
   );

   // Floor division by 2^sh of the signed or unsigned value, wrapped to w bits
   function automatic int unsigned model(int unsigned bits, int unsigned sh,
                                         bit ar, int w);
      longint m;
      longint v;
      m = (longint'(1) << w) - 1;
      v = longint'(bits) & m;
      if (ar && v >= (longint'(1) << (w - 1)))
         v = v - (longint'(1) << w);
      v = v >>> sh;
      return 32'(v & m);
   endfunction

   task automatic run8(input logic [7:0] b, input logic [2:0] s,
                       input logic a, output logic [7:0] r, output int lat);
      @(posedge clk); #1;
      iBits8 = b; shift8 = s; arith8 = a; iValid8 = 1'b1;
      @(posedge clk); #1;
      iValid8 = 1'b0;
      iBits8 = 8'($urandom); shift8 = 3'($urandom); arith8 = 1'($urandom);
      lat = 1;
      while (oValid8 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = oBits8;
   endtask

   task automatic run6(input logic [5:0] b, input logic [2:0] s,
                       input logic a, output logic [5:0] r, output int lat);
      @(posedge clk); #1;
      iBits6 = b; shift6 = s; arith6 = a; iValid6 = 1'b1;
      @(posedge clk); #1;
      iValid6 = 1'b0;
      iBits6 = 6'($urandom); shift6 = 3'($urandom); arith6 = 1'($urandom);
      lat = 1;
      while (oValid6 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = oBits6;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (iReady8 !== 1'b1 || oValid8 !== 1'b0 || oBits8 !== 8'h00) begin
         errors++;
         $display("FAIL reset8: iReady=%b oValid=%b oBits=%h want 1 0 00",
                  iReady8, oValid8, oBits8);
      end
      checks++;
      if (iReady6 !== 1'b1 || oValid6 !== 1'b0 || oBits6 !== 6'h00) begin
         errors++;
         $display("FAIL reset6: iReady=%b oValid=%b oBits=%h want 1 0 00",
                  iReady6, oValid6, oBits6);
      end
   endtask

   task automatic test_logical;
      logic [7:0] r;
      int lat;
      run8(8'hB4, 3'd3, 1'b0, r, lat);
      checks++;
      if (r !== 8'h16) begin
         errors++; $display("FAIL logical: got %h want 16", r);
      end
      checks++;
      if (lat != 4) begin
         errors++; $display("FAIL latency: got %0d want 4", lat);
      end
   endtask

   task automatic test_arith;
      logic [7:0] r;
      int lat;
      run8(8'hB4, 3'd3, 1'b1, r, lat);
      checks++;
      if (r !== 8'hF6) begin
         errors++; $display("FAIL arith_neg: got %h want f6", r);
      end
      run8(8'h74, 3'd3, 1'b1, r, lat);
      checks++;
      if (r !== 8'h0E) begin
         errors++; $display("FAIL arith_pos: got %h want 0e", r);
      end
   endtask

   task automatic test_shift_edges;
      logic [7:0] r;
      int lat;
      run8(8'hB4, 3'd0, 1'b0, r, lat);
      checks++;
      if (r !== 8'hB4 || lat != 4) begin
         errors++;
         $display("FAIL shift0: got %h lat %0d want b4 lat 4", r, lat);
      end
      run8(8'h80, 3'd7, 1'b1, r, lat);
      checks++;
      if (r !== 8'hFF) begin
         errors++; $display("FAIL shift7_arith: got %h want ff", r);
      end
      run8(8'h80, 3'd7, 1'b0, r, lat);
      checks++;
      if (r !== 8'h01) begin
         errors++; $display("FAIL shift7_logic: got %h want 01", r);
      end
   endtask

   task automatic test_width6;
      logic [5:0] r;
      int lat;
      run6(6'h20, 3'd7, 1'b1, r, lat);
      checks++;
      if (r !== 6'h3F || lat != 4) begin
         errors++;
         $display("FAIL w6_arith_sat: got %h lat %0d want 3f lat 4", r, lat);
      end
      run6(6'h20, 3'd7, 1'b0, r, lat);
      checks++;
      if (r !== 6'h00) begin
         errors++; $display("FAIL w6_logic_sat: got %h want 00", r);
      end
   endtask

   task automatic test_random;
      logic [7:0] r8, b8;
      logic [5:0] r6, b6;
      logic [2:0] s;
      logic       a;
      int lat;
      int unsigned exp;
      for (int i = 0; i < 30; i++) begin
         b8 = 8'($urandom); s = 3'($urandom); a = 1'($urandom);
         exp = model(32'(b8), 32'(s), a, 8);
         run8(b8, s, a, r8, lat);
         checks++;
         if (r8 !== exp[7:0] || lat != 4) begin
            errors++;
            $display("FAIL rand8: in %h sh %0d ar %b got %h lat %0d want %h lat 4",
                     b8, s, a, r8, lat, exp[7:0]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         b6 = 6'($urandom); s = 3'($urandom); a = 1'($urandom);
         exp = model(32'(b6), 32'(s), a, 6);
         run6(b6, s, a, r6, lat);
         checks++;
         if (r6 !== exp[5:0] || lat != 4) begin
            errors++;
            $display("FAIL rand6: in %h sh %0d ar %b got %h lat %0d want %h lat 4",
                     b6, s, a, r6, lat, exp[5:0]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] b, r;
      logic [2:0] s;
      logic       a;
      int lat;
      int seen;
      int unsigned exp;
      b = 8'($urandom); s = 3'($urandom); a = 1'($urandom);
      exp = model(32'(b), 32'(s), a, 8);
      oReady8 = 1'b0;
      run8(b, s, a, r, lat);
      checks++;
      if (r !== exp[7:0] || lat != 4) begin
         errors++;
         $display("FAIL bp_result: got %h lat %0d want %h lat 4", r, lat, exp[7:0]);
      end
      for (int i = 0; i < 5; i++) begin
         iValid8 = (i % 2 == 0);
         iBits8 = 8'($urandom);
         @(posedge clk); #1;
         checks++;
         if (oBits8 !== exp[7:0] || iReady8 !== 1'b0 || oValid8 !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: oBits %h iReady %b oValid %b want %h 0 1",
                     oBits8, iReady8, oValid8, exp[7:0]);
         end
      end
      iValid8 = 1'b0;
      oReady8 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (iReady8 !== 1'b1 || oValid8 !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: iReady %b oValid %b want 1 0", iReady8, oValid8);
      end
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (oValid8 === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL bp_no_second: oValid cycles %0d want 0", seen);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] b, r;
      logic [2:0] s;
      logic       a;
      int lat;
      int seen;
      int unsigned exp;
      oReady8 = 1'b1;
      @(posedge clk); #1;
      iBits8 = 8'hB4; shift8 = 3'd5; arith8 = 1'b1; iValid8 = 1'b1;
      @(posedge clk); #1;
      iValid8 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (iReady8 !== 1'b1 || oValid8 !== 1'b0 || oBits8 !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid: iReady %b oValid %b oBits %h want 1 0 00",
                  iReady8, oValid8, oBits8);
      end
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (oValid8 === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL rst_mid_pulse: oValid cycles %0d want 0", seen);
      end
      b = 8'($urandom); s = 3'($urandom); a = 1'($urandom);
      exp = model(32'(b), 32'(s), a, 8);
      run8(b, s, a, r, lat);
      checks++;
      if (r !== exp[7:0] || lat != 4) begin
         errors++;
         $display("FAIL rst_mid_fresh: got %h lat %0d want %h lat 4", r, lat, exp[7:0]);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] b1, b2, r;
      logic [2:0] s1, s2;
      logic       a1, a2;
      int lat;
      int unsigned exp1, exp2;
      b1 = 8'($urandom); s1 = 3'($urandom); a1 = 1'($urandom);
      b2 = 8'($urandom); s2 = 3'($urandom); a2 = 1'($urandom);
      exp1 = model(32'(b1), 32'(s1), a1, 8);
      exp2 = model(32'(b2), 32'(s2), a2, 8);
      oReady8 = 1'b1;
      run8(b1, s1, a1, r, lat);
      checks++;
      if (r !== exp1[7:0]) begin
         errors++; $display("FAIL b2b_first: got %h want %h", r, exp1[7:0]);
      end
      iBits8 = b2; shift8 = s2; arith8 = a2; iValid8 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (iReady8 !== 1'b1 || oValid8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: iReady %b oValid %b want 1 0", iReady8, oValid8);
      end
      @(posedge clk); #1;
      iValid8 = 1'b0;
      iBits8 = 8'($urandom);
      lat = 1;
      while (oValid8 !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (oBits8 !== exp2[7:0] || lat != 4) begin
         errors++;
         $display("FAIL b2b_second: got %h lat %0d want %h lat 4",
                  oBits8, lat, exp2[7:0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      iBits8 = '0; shift8 = '0; arith8 = 1'b0; iValid8 = 1'b0; oReady8 = 1'b1;
      iBits6 = '0; shift6 = '0; arith6 = 1'b0; iValid6 = 1'b0; oReady6 = 1'b1;
      test_reset();
      test_logical();
      test_arith();
      test_shift_edges();
      test_width6();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
